// File: rtl/sound_pkg.sv
// Shared types and default timing/frequency constants for the beep scheduler.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned SND_FREQ_W      = 52;
    localparam int unsigned SND_CNT_W       = 32;
    localparam int unsigned SND_SHORT_TICKS = 5000000;
    localparam int unsigned SND_LONG_TICKS  = 20000000;
    localparam int unsigned SND_GAP_TICKS   = 2500000;
    localparam int unsigned SND_FREQ_SHORT  = 32000;
    localparam int unsigned SND_FREQ_LONG   = 16000;

endpackage

// File: rtl/sound_rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or above ptr_i, with wrap.
module sound_rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] pend_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] win_idx_o,
    output logic [N_REQ-1:0] win_oh_o,
    output logic             valid_o
);

    always_comb begin
        logic [PTR_W:0] j;
        valid_o   = 1'b0;
        win_idx_o = '0;
        win_oh_o  = '0;
        j         = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (j >= (PTR_W+1)'(N_REQ)) j = j - (PTR_W+1)'(N_REQ);
            if (!valid_o && pend_i[j[PTR_W-1:0]]) begin
                valid_o                = 1'b1;
                win_idx_o              = j[PTR_W-1:0];
                win_oh_o[j[PTR_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_beep_scheduler.sv
// Latches short/long beep requests, arbitrates round-robin and times tone + gap
// for the tone generator.
module sound_beep_scheduler #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned FREQ_W      = sound_pkg::SND_FREQ_W,
    parameter int unsigned SHORT_TICKS = sound_pkg::SND_SHORT_TICKS,
    parameter int unsigned LONG_TICKS  = sound_pkg::SND_LONG_TICKS,
    parameter int unsigned GAP_TICKS   = sound_pkg::SND_GAP_TICKS,
    parameter int unsigned FREQ_SHORT  = sound_pkg::SND_FREQ_SHORT,
    parameter int unsigned FREQ_LONG   = sound_pkg::SND_FREQ_LONG,
    parameter int unsigned CNT_W       = sound_pkg::SND_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [N_REQ-1:0]  req_short,
    input  logic [N_REQ-1:0]  req_long,
    output logic [N_REQ-1:0]  grant,
    output logic              busy,
    output logic              s_enable,
    output logic [FREQ_W-1:0] sonido
);
    import sound_pkg::*;

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  pend_s_q, pend_s_d, pend_l_q, pend_l_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              s_en_q, s_en_d, busy_q, busy_d;
    logic [FREQ_W-1:0] sonido_q, sonido_d;

    logic [PTR_W-1:0]  win_idx;
    logic [N_REQ-1:0]  win_oh;
    logic              win_vld;
    logic              go, win_long;

    sound_rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .pend_i    (pend_s_q | pend_l_q),
        .ptr_i     (ptr_q),
        .win_idx_o (win_idx),
        .win_oh_o  (win_oh),
        .valid_o   (win_vld)
    );

    assign go       = (state_q == IDLE) && enable && win_vld;
    assign win_long = |(pend_l_q & win_oh);

    // A request in the granting cycle re-arms the latch after the clear.
    always_comb begin
        if (enable) begin
            pend_s_d = (pend_s_q & ~(go ? win_oh : '0)) | req_short;
            pend_l_d = (pend_l_q & ~(go ? win_oh : '0)) | req_long;
        end else begin
            pend_s_d = '0;
            pend_l_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        s_en_d   = s_en_q;
        sonido_d = sonido_q;
        if (!enable) begin
            state_d  = IDLE;
            s_en_d   = 1'b0;
            sonido_d = '0;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    state_d  = TONE;
                    grant_d  = win_oh;
                    s_en_d   = 1'b1;
                    sonido_d = win_long ? FREQ_W'(FREQ_LONG) : FREQ_W'(FREQ_SHORT);
                    cnt_d    = win_long ? CNT_W'(LONG_TICKS - 1) : CNT_W'(SHORT_TICKS - 1);
                    ptr_d    = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
                TONE: if (cnt_q == '0) begin
                    state_d  = GAP;
                    s_en_d   = 1'b0;
                    sonido_d = '0;
                    cnt_d    = CNT_W'(GAP_TICKS - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                GAP: if (cnt_q == '0) state_d = IDLE;
                     else cnt_d = cnt_q - 1'b1;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pend_s_q <= '0;
            pend_l_q <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            s_en_q   <= 1'b0;
            sonido_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_s_q <= pend_s_d;
            pend_l_q <= pend_l_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            s_en_q   <= s_en_d;
            sonido_q <= sonido_d;
            busy_q   <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign s_enable = s_en_q;
    assign sonido   = sonido_q;

endmodule

// File: tb/tb_sound_beep_scheduler.sv
// Randomized + directed bench; expectations come from a remaining-cycles beep model.
module tb_sound_beep_scheduler;

    localparam int N  = 2;
    localparam int FW = 52;
    localparam int ST = 4;
    localparam int LT = 8;
    localparam int GT = 2;
    localparam int FS = 32000;
    localparam int FL = 16000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  req_short = '0;
    logic [N-1:0]  req_long = '0;
    logic [N-1:0]  grant;
    logic          busy;
    logic          s_enable;
    logic [FW-1:0] sonido;

    sound_beep_scheduler #(
        .N_REQ(N), .FREQ_W(FW), .SHORT_TICKS(ST), .LONG_TICKS(LT), .GAP_TICKS(GT),
        .FREQ_SHORT(FS), .FREQ_LONG(FL), .CNT_W(32)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .req_short(req_short), .req_long(req_long),
        .grant(grant), .busy(busy), .s_enable(s_enable), .sonido(sonido)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: cycles of tone left, cycles of gap left, pending sets, RR pointer.
    int          m_tone, m_gap, m_ptr;
    bit [N-1:0]  m_ps, m_pl, m_grant;
    int          m_freq;

    task automatic model_reset();
        m_tone = 0; m_gap = 0; m_ptr = 0; m_ps = '0; m_pl = '0; m_grant = '0; m_freq = 0;
    endtask

    task automatic model_step(input bit en, input bit [N-1:0] rs, input bit [N-1:0] rl);
        bit         idle;
        bit [N-1:0] pend, clr;
        bit         found;
        int         w;
        idle = (m_tone == 0) && (m_gap == 0);
        clr = '0;
        m_grant = '0;
        if (!en) begin
            m_ps = '0; m_pl = '0; m_tone = 0; m_gap = 0;
        end else begin
            if (idle) begin
                pend = m_ps | m_pl;
                found = 0;
                w = 0;
                for (int k = 0; k < N; k++)
                    if (!found && pend[(m_ptr + k) % N]) begin
                        found = 1;
                        w = (m_ptr + k) % N;
                    end
                if (found) begin
                    m_grant[w] = 1'b1;
                    clr[w] = 1'b1;
                    m_tone = m_pl[w] ? LT : ST;
                    m_freq = m_pl[w] ? FL : FS;
                    m_ptr = (w + 1) % N;
                end
            end else if (m_tone > 0) begin
                m_tone--;
                if (m_tone == 0) m_gap = GT;
            end else begin
                m_gap--;
            end
            m_ps = (m_ps & ~clr) | rs;
            m_pl = (m_pl & ~clr) | rl;
        end
    endtask

    int hi_cnt;

    // One clock: model follows the sampled inputs, outputs checked 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step(enable, req_short, req_long);
        #1;
        chk("grant",    64'(grant),    64'(m_grant));
        chk("s_enable", 64'(s_enable), 64'(m_tone > 0));
        chk("sonido",   64'(sonido),   (m_tone > 0) ? 64'(m_freq) : 64'd0);
        chk("busy",     64'(busy),     64'((m_tone > 0) || (m_gap > 0)));
        if (s_enable) hi_cnt++;
    endtask

    task automatic drive(input bit en, input bit [N-1:0] rs, input bit [N-1:0] rl);
        enable = en; req_short = rs; req_long = rl;
        cycle();
        req_short = '0; req_long = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_s_enable", 64'(s_enable), 64'd0);
        chk("rst_sonido",   64'(sonido),   64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_grant",    64'(grant),    64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        enable  = 1'b1;

        // Quiet with enable high.
        idle_cycles(10);

        // Single short beep from requester 0.
        hi_cnt = 0;
        drive(1, 2'b01, 2'b00);
        idle_cycles(12);
        chk("short_len", 64'(hi_cnt), 64'(ST));

        // Short from 0 and long from 1 together.
        hi_cnt = 0;
        drive(1, 2'b01, 2'b10);
        idle_cycles(25);
        chk("pair_len", 64'(hi_cnt), 64'(ST + LT));

        // Short + long from the same requester collapse to one long beep.
        hi_cnt = 0;
        drive(1, 2'b10, 2'b10);
        idle_cycles(20);
        chk("merge_len", 64'(hi_cnt), 64'(LT));

        // Enable drop during a long beep with requester 0 pending.
        drive(1, 2'b00, 2'b10);
        drive(1, 2'b01, 2'b00);
        idle_cycles(1);
        drive(0, 2'b00, 2'b00);
        enable = 1'b1;
        hi_cnt = 0;
        idle_cycles(15);
        chk("abort_quiet", 64'(hi_cnt), 64'd0);

        // Async reset mid-tone.
        drive(1, 2'b01, 2'b00);
        idle_cycles(2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_s_enable", 64'(s_enable), 64'd0);
        chk("arst_sonido",   64'(sonido),   64'd0);
        chk("arst_busy",     64'(busy),     64'd0);
        chk("arst_grant",    64'(grant),    64'd0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        hi_cnt = 0;
        drive(1, 2'b00, 2'b01);
        idle_cycles(14);
        chk("post_rst_len", 64'(hi_cnt), 64'(LT));

        // Randomized traffic with occasional enable drops and level requests.
        for (int c = 0; c < 3000; c++) begin
            bit [N-1:0] rs, rl;
            rs = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            rl = ($urandom_range(0, 11) == 0) ? N'($urandom) : '0;
            if ((c / 500) % 2 == 1 && ($urandom_range(0, 3) != 0)) rs[0] = 1'b1;
            enable = ($urandom_range(0, 60) != 0);
            req_short = rs;
            req_long  = rl;
            cycle();
        end
        enable = 1'b1; req_short = '0; req_long = '0;
        idle_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
